// File: rtl/cdc_pkg.sv
// Shared types and defaults for the req/ack clock-domain-crossing controller.
package cdc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    REL  = 2'd2
  } hs_state_t;

  localparam int CDC_SYNC_STAGES = 2;
  localparam int CDC_CNT_W       = 4;

endpackage

// File: rtl/sync_nff.sv
// Single-bit N-stage flip-flop synchroniser with asynchronous active-low reset.
module sync_nff #(
  parameter int STAGES = 2
) (
  input  logic clka,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Plain shift chain; the first flop is the only one that sees the async input.
  always_ff @(posedge clka or negedge rstn) begin
    if (!rstn) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/cdc_hs_ctrl.sv
// Source-side four-phase req/ack handshake controller with an optional pending-event queue.
// Define CDC_HS_QUEUE_EN to enable the saturating pending counter; otherwise pend_cnt is tied to 0.
module cdc_hs_ctrl
  import cdc_pkg::*;
#(
  parameter int CNT_W       = CDC_CNT_W,
  parameter int SYNC_STAGES = CDC_SYNC_STAGES
) (
  input  logic             clka,
  input  logic             rstn,
  input  logic             pulse_in,
  input  logic             ack_in,
  output logic             req_out,
  output logic             busy,
  output logic [CNT_W-1:0] pend_cnt,
  output logic             done,
  output logic             drop
);

  hs_state_t state, nextState;
  logic      ackS;
  logic      hasWork;
  logic      launch;
  logic      doneNext;
  logic      dropNext;

  sync_nff #(.STAGES(SYNC_STAGES)) ackSync (
    .clka (clka),
    .rstn (rstn),
    .d    (ack_in),
    .q    (ackS)
  );

`ifdef CDC_HS_QUEUE_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  logic [CNT_W-1:0] pendNext;

  assign hasWork = pulse_in || (pend_cnt != '0);

  // Net count change is pulse minus launch; a pulse that cannot be stored is dropped.
  always_comb begin
    pendNext = pend_cnt;
    dropNext = 1'b0;
    if (pulse_in && !launch) begin
      if (pend_cnt == CNT_MAX) begin
        dropNext = 1'b1;
      end else begin
        pendNext = pend_cnt + 1'b1;
      end
    end else if (!pulse_in && launch) begin
      pendNext = pend_cnt - 1'b1;
    end
  end

  always_ff @(posedge clka or negedge rstn) begin
    if (!rstn) begin
      pend_cnt <= '0;
    end else begin
      pend_cnt <= pendNext;
    end
  end
`else
  assign hasWork  = pulse_in;
  assign dropNext = pulse_in && !launch;
  assign pend_cnt = '0;
`endif

  always_comb begin
    nextState = state;
    launch    = 1'b0;
    doneNext  = 1'b0;
    case (state)
      IDLE: begin
        if (!ackS && hasWork) begin
          launch    = 1'b1;
          nextState = REQ;
        end
      end
      REQ: begin
        if (ackS) begin
          nextState = REL;
        end
      end
      REL: begin
        if (!ackS) begin
          nextState = IDLE;
          doneNext  = 1'b1;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // Outputs are derived from the next state so every output leaves a flop.
  always_ff @(posedge clka or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      req_out <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      drop    <= 1'b0;
    end else begin
      state   <= nextState;
      req_out <= (nextState == REQ);
      busy    <= (nextState != IDLE);
      done    <= doneNext;
      drop    <= dropNext;
    end
  end

endmodule

// File: tb/tb_cdc_hs_ctrl.sv
// Self-checking bench for cdc_hs_ctrl: vector table, hand sequences and a randomised model run.
module tb_cdc_hs_ctrl;

`ifdef CDC_HS_QUEUE_EN
  localparam int QE = 1;
`else
  localparam int QE = 0;
`endif
  localparam int STAGES = 2;
  localparam int PMAX   = 15;

  logic clka = 1'b0;
  logic rstn = 1'b1;
  logic pulse_in = 1'b0;
  logic ack_in = 1'b0;
  logic req_out, busy, done, drop;
  logic [3:0] pend_cnt;

  logic satPulse = 1'b0;
  logic satReq, satBusy, satDone, satDrop;
  logic [1:0] satPend;

  cdc_hs_ctrl #(.CNT_W(4), .SYNC_STAGES(STAGES)) dut (
    .clka(clka), .rstn(rstn), .pulse_in(pulse_in), .ack_in(ack_in),
    .req_out(req_out), .busy(busy), .pend_cnt(pend_cnt), .done(done), .drop(drop)
  );

  cdc_hs_ctrl #(.CNT_W(2), .SYNC_STAGES(STAGES)) dutSat (
    .clka(clka), .rstn(rstn), .pulse_in(satPulse), .ack_in(1'b0),
    .req_out(satReq), .busy(satBusy), .pend_cnt(satPend), .done(satDone), .drop(satDrop)
  );

  always #5 clka = ~clka;

  int tests = 0;
  int failures = 0;

  // Reference model: request level, busy flag, integer queue depth, ack history queue
  logic mBusy, mReq, mDone, mDrop;
  int   mPend;
  logic ackQ[$];

  int   reqRises, doneCount, dropCount, peakPend;
  logic prevReq;
  logic ackLvl = 1'b0;
  int   ackWait = 0;

  typedef struct {
    logic pulse;
    logic ack;
    logic req;
    logic busy;
    logic done;
  } vec_t;
  vec_t vecs[12];

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic resetModel();
    mBusy = 0; mReq = 0; mDone = 0; mDrop = 0; mPend = 0;
    ackQ.delete();
    for (int i = 0; i < STAGES; i++) ackQ.push_back(1'b0);
  endtask

  task automatic modelStep(input logic p, input logic a);
    logic s, launch;
    int   nxt;
    s = ackQ.pop_front();
    ackQ.push_back(a);
    launch = !mBusy && !s && (p || mPend > 0);
    mDone = 0;
    if (!mBusy) begin
      if (launch) begin mBusy = 1; mReq = 1; end
    end else if (mReq) begin
      if (s) mReq = 0;
    end else if (!s) begin
      mBusy = 0; mDone = 1;
    end
    if (QE == 1) begin
      nxt   = mPend + int'(p) - int'(launch);
      mDrop = (nxt > PMAX);
      mPend = (nxt > PMAX) ? PMAX : nxt;
    end else begin
      mDrop = p && !launch;
    end
  endtask

  task automatic clearStats();
    reqRises = 0; doneCount = 0; dropCount = 0; peakPend = 0; prevReq = req_out;
  endtask

  task automatic checkOutput();
    compare("req_out", req_out, mReq);
    compare("busy", busy, mBusy);
    compare("pend_cnt", pend_cnt, mPend);
    compare("done", done, mDone);
    compare("drop", drop, mDrop);
  endtask

  // Drives one cycle of inputs, advances the model across the edge, then checks #1 later.
  task automatic applyStimulus(input logic p, input logic a);
    pulse_in = p;
    ack_in   = a;
    modelStep(p, a);
    @(posedge clka);
    #1;
    if (req_out === 1'b1 && prevReq !== 1'b1) reqRises++;
    prevReq = req_out;
    if (done === 1'b1) doneCount++;
    if (drop === 1'b1) dropCount++;
    if (int'(pend_cnt) > peakPend) peakPend = int'(pend_cnt);
    checkOutput();
  endtask

  // Destination responder: ack follows the modelled request level after lat cycles.
  task automatic autoStep(input logic p, input int lat);
    if (ackLvl != mReq) begin
      if (ackWait >= lat) begin
        ackLvl  = mReq;
        ackWait = 0;
      end else begin
        ackWait++;
      end
    end else begin
      ackWait = 0;
    end
    applyStimulus(p, ackLvl);
  endtask

  task automatic doReset(input logic a);
    ackLvl  = a;
    ack_in  = a;
    ackWait = 0;
    pulse_in = 1'b0;
    rstn = 1'b0;
    resetModel();
    #1;
    checkOutput();
    @(posedge clka);
    #1;
    rstn = 1'b1;
    clearStats();
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    #2;
    doReset(1'b0);
    compare("rst_sat_pend", satPend, 0);
    compare("rst_sat_req", satReq, 0);

    // Single event against the vector table
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].pulse, vecs[i].ack);
      compare($sformatf("single_req[%0d]", i), req_out, vecs[i].req);
      compare($sformatf("single_busy[%0d]", i), busy, vecs[i].busy);
      compare($sformatf("single_done[%0d]", i), done, vecs[i].done);
      compare($sformatf("single_pend[%0d]", i), pend_cnt, 0);
    end
    compare("single_req_periods", reqRises, 1);
    compare("single_done_count", doneCount, 1);

    // Burst of five pulses while idle
    doReset(1'b0);
    for (int i = 0; i < 5; i++) autoStep(1'b1, 3);
    for (int i = 0; i < 120; i++) autoStep(1'b0, 3);
    compare("burst_handshakes", reqRises, QE ? 5 : 1);
    compare("burst_done_count", doneCount, QE ? 5 : 1);
    compare("burst_peak_pend", peakPend, QE ? 4 : 0);
    compare("burst_drops", dropCount, QE ? 0 : 4);
    compare("burst_final_pend", pend_cnt, 0);

    // Pulse while busy
    doReset(1'b0);
    autoStep(1'b1, 3);
    autoStep(1'b1, 3);
    compare("busy_pulse_drop", drop, QE ? 0 : 1);
    compare("busy_pulse_pend", pend_cnt, QE ? 1 : 0);
    for (int i = 0; i < 40; i++) autoStep(1'b0, 3);
    compare("busy_pulse_handshakes", reqRises, QE ? 2 : 1);

    // Saturation on the 2-bit instance with ack held low
    doReset(1'b0);
    for (int k = 1; k <= 5; k++) begin
      satPulse = 1'b1;
      applyStimulus(1'b0, 1'b0);
      if (k == 4) compare("sat_pend_4", satPend, QE ? 3 : 0);
    end
    satPulse = 1'b0;
    compare("sat_pend_5", satPend, QE ? 3 : 0);
    compare("sat_drop_5", satDrop, 1);
    compare("sat_req_held", satReq, 1);
    applyStimulus(1'b0, 1'b0);
    compare("sat_drop_clears", satDrop, 0);

    // Stale acknowledge held through reset release
    doReset(1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1);
    compare("stale_req_low", req_out, 0);
    compare("stale_pend", pend_cnt, QE ? 1 : 0);
    compare("stale_no_launch", reqRises, 0);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0);
    compare("stale_launch_after_release", reqRises, QE ? 1 : 0);
    ackLvl = 1'b0;
    for (int i = 0; i < 30; i++) autoStep(1'b0, 2);

    // Reset in the middle of REQ with events queued
    doReset(1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0);
    compare("midreq_busy", busy, 1);
    compare("midreq_pend", pend_cnt, QE ? 2 : 0);
    rstn = 1'b0;
    resetModel();
    #1;
    compare("midreq_rst_req", req_out, 0);
    compare("midreq_rst_busy", busy, 0);
    compare("midreq_rst_pend", pend_cnt, 0);
    compare("midreq_rst_done", done, 0);
    compare("midreq_rst_drop", drop, 0);
    @(posedge clka);
    #1;
    rstn = 1'b1;
    clearStats();
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0);
    compare("midreq_no_req_after_reset", reqRises, 0);

    // Randomised run against the model
    doReset(1'b0);
    for (int i = 0; i < 2000; i++) begin
      autoStep($urandom_range(0, 3) == 0, $urandom_range(0, 4));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/cdc_hs_ctrl.md
# cdc_hs_ctrl

Source-side controller for a four-phase req/ack handshake across an asynchronous clock boundary. Accepts single-cycle event pulses in the clka domain and queues them in a saturating pending counter. Sequences one request per event toward the destination domain, and synchronises the returning acknowledge through an internal N-stage flip-flop synchroniser. It sits in front of the destination-side 2-FF synchroniser and guarantees that the request level never changes faster than the destination can sample it.

## Interface
- CNT_W, 4, pending-event counter width; maximum queued events is 2^CNT_W-1
- SYNC_STAGES, 2, flip-flop stages on ack_in (minimum 2)
- clka  in  1  source clock; all logic on rising edge
- rstn  in  1  asynchronous active-low reset
- pulse_in  in  1  single-cycle event, clka domain
- ack_in  in  1  acknowledge level from destination domain, asynchronous to clka
- req_out  out  1  registered request level to destination domain
- busy  out  1  handshake in progress (state != IDLE)
- pend_cnt  out  CNT_W  events accepted but not yet launched
- done  out  1  one-cycle pulse when a handshake completes
- drop  out  1  one-cycle pulse when an event is lost

## Operation
- The ack_in signal passes through SYNC_STAGES flops to form ack_s; no other logic touches ack_in.
- FSM states:
  - IDLE: req_out=0.
  - REQ: req_out=1, waiting for ack_s=1.
  - REL: req_out=0, waiting for ack_s=0.
- Launch condition: launch = (state==IDLE) && !ack_s && (pulse_in || pend_cnt!=0). On launch: next state REQ, req_out<=1.
- REQ → REL when ack_s=1; req_out<=0.
- REL → IDLE when ack_s=0; done=1 for that cycle.
- Counter update: pend_cnt_next = pend_cnt + pulse_in − launch.
  - Simultaneous pulse_in and launch with pend_cnt>0 leaves the count unchanged.
  - A launch with pend_cnt=0 consumes pulse_in directly.
- Saturation: pulse_in && !launch && pend_cnt==2^CNT_W−1 → drop=1, pend_cnt unchanged.
- IDLE lasts at least one cycle after done. There is no direct REL→REQ transition.
- Stale acknowledge: ack_s=1 while in IDLE (e.g. destination not yet reset) blocks any launch. Events keep queueing.

## Timing
- Reset values:
  - req_out=0, busy=0, pend_cnt=0, done=0, drop=0
  - state=IDLE, all synchroniser flops 0
- Reset is asynchronous assert, synchronous-to-clka deassert assumed upstream. Reset mid-handshake abandons the transfer and clears the queue.
- pulse_in at edge N in IDLE with ack_s=0 → req_out=1 and busy=1 after edge N.
- An ack_in rise is visible on ack_s SYNC_STAGES edges later; req_out falls on the following edge.
- done asserts on the edge where ack_s=0 is first seen in REL. The earliest next launch is one edge later.
- Minimum round trip with an instant ack: 1 + 2·(SYNC_STAGES+1) cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- CDC_HS_QUEUE_EN defined: pending counter as above.
- CDC_HS_QUEUE_EN undefined:
  - no counter; pend_cnt is tied to 0
  - a pulse_in is accepted only when the launch condition holds
  - any pulse_in while busy or while ack_s=1 gives drop=1
  - CNT_W is unused

## Structure
- Shared package cdc_pkg holds:
  - the state typedef: IDLE=2'd0, REQ=2'd1, REL=2'd2
  - default constants CDC_SYNC_STAGES=2 and CDC_CNT_W=4
- One sub-module, sync_nff: a parameterised SYNC_STAGES-deep single-bit synchroniser with async active-low reset, used for ack_in.
- The FSM and counter live in cdc_hs_ctrl.

## Test plan
- Single event: reset, one pulse_in; the bench responds with ack_in rising 3 cycles after req_out and falling 3 cycles after req_out falls. Required: exactly one req_out high period, done=1 once, pend_cnt stays 0.
- Burst: 5 consecutive pulse_in cycles while idle. Required: pend_cnt peaks at 4, 5 req_out handshakes in order, pend_cnt returns to 0, no drop.
- Saturation, CNT_W=2, ack_in held low so the FSM stays in REQ: 5 pulses. Required: pend_cnt=3 and drop=1 on the 5th pulse.
- Stale ack: hold ack_in=1 through reset release, then pulse_in. Required: req_out stays 0 and pend_cnt=1 until ack_in falls, then launch follows.
- Reset mid-REQ with pend_cnt=2. Required: all outputs 0 immediately and no req_out after reset release until a new pulse_in.
- With CDC_HS_QUEUE_EN undefined, pulse_in while busy. Required: drop=1, pend_cnt=0, only the first handshake occurs.
